basket_catch_tracker: RTL and testbench

- Multi-cube successor to the single-cube basket check of the falling-cubes game.
- Once per video frame, snapshots the positions of up to N_CUBES falling cubes and the basket, then scans them one cube per clock.
- Emits one-shot catch/miss events per cube and maintains score, lives and game-over state.
- Sits between the cube motion generators / basket controller and the display/score logic.

---
 rtl/falling_cubes_pkg.sv | 13 +
 rtl/catch_window_cmp.sv | 20 ++
 rtl/basket_catch_tracker.sv | 109 ++++++++++
 tb/tb_basket_catch_tracker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/falling_cubes_pkg.sv
// falling_cubes_pkg: shared geometry, lives and FSM encoding for the falling-cubes game.
package falling_cubes_pkg;
  localparam int COORD_W  = 10;
  localparam int CUBE_W   = 64;
  localparam int BASKET_W = 96;
  localparam int BASKET_Y = 436;
  localparam int FLOOR_Y  = 480;
  localparam logic [3:0] LIVES_INIT = 4'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, SCAN = ST_SCAN, DONE = ST_DONE} state_t;
endpackage

// File: rtl/catch_window_cmp.sv
// catch_window_cmp: classifies one cube against the basket window as caught or missed.
module catch_window_cmp
  import falling_cubes_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] basket_x,
  output logic               caught,
  output logic               missed
);
  localparam int EW = COORD_W + 1;
  // one extra bit so right-edge sums near the screen edge cannot wrap
  logic [EW-1:0] xe, ye, bxe;
  assign xe  = {1'b0, x};
  assign ye  = {1'b0, y};
  assign bxe = {1'b0, basket_x};
  assign missed = ye >= EW'(FLOOR_Y);
  assign caught = (bxe <= xe) && (xe + EW'(CUBE_W) <= bxe + EW'(BASKET_W)) &&
                  (ye >= EW'(BASKET_Y)) && !missed;
endmodule

// File: rtl/basket_catch_tracker.sv
// basket_catch_tracker: per-frame snapshot and one-cube-per-clock scan producing
// catch/miss pulses, saturating score, lives and game-over state.
module basket_catch_tracker
  import falling_cubes_pkg::*;
#(
  parameter int N_CUBES = 4,
  parameter int SCORE_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic                       game_restart,
  input  logic [N_CUBES*COORD_W-1:0] cube_x,
  input  logic [N_CUBES*COORD_W-1:0] cube_y,
  input  logic [N_CUBES-1:0]         cube_active,
  input  logic [COORD_W-1:0]         basket_x,
  output logic [N_CUBES-1:0]         catch_pulse,
  output logic [N_CUBES-1:0]         miss_pulse,
  output logic [SCORE_W-1:0]         score,
  output logic [3:0]                 lives,
  output logic                       game_over,
  output logic                       scan_busy,
  output logic                       frame_done,
  output logic                       frame_overrun
);
  localparam int IDX_W = N_CUBES > 1 ? $clog2(N_CUBES) : 1;
  state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic [N_CUBES*COORD_W-1:0] snap_x, snap_y;
  logic [N_CUBES-1:0] snap_act, resolved, one_hot, hit_mask;
  logic [COORD_W-1:0] snap_bx, cur_x, cur_y;
  logic start, last, eval, caught, missed, catch_hit, miss_hit;
  assign start = state == IDLE && frame_tick && !game_over;
  assign last = idx == IDX_W'(N_CUBES - 1);
  assign cur_x = snap_x[idx*COORD_W +: COORD_W];
  assign cur_y = snap_y[idx*COORD_W +: COORD_W];
  assign eval = state == SCAN && snap_act[idx] && !resolved[idx] && !game_over;
  assign catch_hit = eval && caught;
  assign miss_hit = eval && missed;
  assign hit_mask = (catch_hit || miss_hit) ? one_hot : '0;
  assign scan_busy = state != IDLE;
  assign frame_done = state == DONE;
  catch_window_cmp u_cmp (
    .x        (cur_x),
    .y        (cur_y),
    .basket_x (snap_bx),
    .caught   (caught),
    .missed   (missed)
  );
  always_comb begin
    one_hot = '0;
    one_hot[idx] = 1'b1;
  end
  always_comb begin
    state_n = game_restart ? IDLE :
              start ? SCAN :
              (state == SCAN && last) ? DONE :
              state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      snap_x <= '0;
      snap_y <= '0;
      snap_act <= '0;
      snap_bx <= '0;
      resolved <= '0;
      catch_pulse <= '0;
      miss_pulse <= '0;
      score <= '0;
      lives <= LIVES_INIT;
      game_over <= 1'b0;
      frame_overrun <= 1'b0;
    end else if (game_restart) begin
      idx <= '0;
      resolved <= '0;
      catch_pulse <= '0;
      miss_pulse <= '0;
      score <= '0;
      lives <= LIVES_INIT;
      game_over <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      catch_pulse <= catch_hit ? one_hot : '0;
      miss_pulse <= miss_hit ? one_hot : '0;
      // a cube leaving the field re-arms its channel for the next fall
      resolved <= (resolved | hit_mask) & cube_active;
      if (start) begin
        snap_x <= cube_x;
        snap_y <= cube_y;
        snap_act <= cube_active;
        snap_bx <= basket_x;
        idx <= '0;
      end else if (state == SCAN) begin
        idx <= last ? '0 : idx + 1'b1;
      end
      if (catch_hit && score != '1) score <= score + 1'b1;
      if (miss_hit) begin
        lives <= lives - 1'b1;
        game_over <= lives == 4'd1;
      end
      if (frame_tick && state != IDLE) frame_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_basket_catch_tracker.sv
// tb_basket_catch_tracker: directed frames with a pulse scoreboard for basket_catch_tracker.
module tb_basket_catch_tracker;
  localparam int N = 4;
  localparam int W = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_tick = 1'b0;
  logic game_restart = 1'b0;
  logic [N*W-1:0] cube_x = '0;
  logic [N*W-1:0] cube_y = '0;
  logic [N-1:0] cube_active = '0;
  logic [W-1:0] basket_x = '0;
  logic [N-1:0] catch_pulse, miss_pulse;
  logic [7:0] score;
  logic [3:0] lives;
  logic game_over, scan_busy, frame_done, frame_overrun;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int d0;
  logic [2*N-1:0] sb[$];

  basket_catch_tracker #(.N_CUBES(N), .SCORE_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .game_restart  (game_restart),
    .cube_x        (cube_x),
    .cube_y        (cube_y),
    .cube_active   (cube_active),
    .basket_x      (basket_x),
    .catch_pulse   (catch_pulse),
    .miss_pulse    (miss_pulse),
    .score         (score),
    .lives         (lives),
    .game_over     (game_over),
    .scan_busy     (scan_busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // every pulse pattern must match the oldest expectation queued by the stimulus
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) done_cnt++;
      if ((catch_pulse | miss_pulse) != '0) begin
        if (sb.size() == 0) chk("sb_unexpected", {24'd0, catch_pulse, miss_pulse}, 0);
        else chk("sb_pulse", {24'd0, catch_pulse, miss_pulse}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic set_cube(input int i, input int x, input int y, input logic a);
    cube_x[i*W +: W] = W'(x);
    cube_y[i*W +: W] = W'(y);
    cube_active[i] = a;
  endtask

  task automatic respawn(input int i, input int x, input int y);
    @(negedge clk) cube_active[i] = 1'b0;
    @(negedge clk) set_cube(i, x, y, 1'b1);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", {31'd0, frame_done}, 1);
    @(negedge clk);
  endtask

  task automatic frame();
    tick();
    wait_done();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_flags", {game_over, scan_busy, frame_done, frame_overrun}, 0);
    chk("rst_pulses", {catch_pulse, miss_pulse}, 0);
    @(negedge clk) rst_n = 1'b1;
    basket_x = 10'd100;
    set_cube(0, 116, 440, 1'b1);
    sb.push_back({4'b0001, 4'b0000});
    tick();
    @(negedge clk);
    chk("catch_2cyc", catch_pulse, 1);
    chk("busy_in_scan", scan_busy, 1);
    wait_done();
    chk("score_first", score, 1);
    frame();
    chk("score_no_recount", score, 1);
    respawn(0, 116, 440);
    sb.push_back({4'b0001, 4'b0000});
    frame();
    chk("score_respawn", score, 2);
    @(negedge clk) set_cube(0, 116, 440, 1'b0);
    basket_x = 10'd1000;
    set_cube(1, 1000, 450, 1'b1);
    sb.push_back({4'b0010, 4'b0000});
    frame();
    chk("score_edge_1000", score, 3);
    basket_x = 10'd960;
    respawn(1, 993, 450);
    frame();
    chk("score_right_out", score, 3);
    respawn(1, 992, 450);
    sb.push_back({4'b0010, 4'b0000});
    frame();
    chk("score_right_in", score, 4);
    basket_x = 10'd100;
    respawn(1, 100, 450);
    sb.push_back({4'b0010, 4'b0000});
    frame();
    chk("score_left_in", score, 5);
    respawn(1, 99, 450);
    frame();
    chk("score_left_out", score, 5);
    chk("lives_after_catches", lives, 3);
    @(negedge clk) cube_active = '0;
    d0 = done_cnt;
    tick();
    tick();
    wait_done();
    repeat (8) @(negedge clk);
    chk("overrun_set", frame_overrun, 1);
    chk("overrun_one_done", done_cnt - d0, 1);
    chk("overrun_idle", scan_busy, 0);
    @(negedge clk) game_restart = 1'b1;
    @(negedge clk) game_restart = 1'b0;
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    chk("restart_flags", {game_over, frame_overrun}, 0);
    set_cube(0, 0, 480, 1'b1);
    set_cube(1, 200, 480, 1'b1);
    set_cube(2, 500, 480, 1'b1);
    sb.push_back({4'b0000, 4'b0001});
    sb.push_back({4'b0000, 4'b0010});
    sb.push_back({4'b0000, 4'b0100});
    tick();
    @(negedge clk);
    chk("miss0", miss_pulse, 1);
    chk("lives_2", lives, 2);
    @(negedge clk);
    chk("miss1", miss_pulse, 2);
    chk("lives_1", lives, 1);
    @(negedge clk);
    chk("miss2", miss_pulse, 4);
    chk("lives_0", lives, 0);
    chk("game_over_set", game_over, 1);
    wait_done();
    chk("score_after_miss", score, 0);
    d0 = done_cnt;
    tick();
    chk("gameover_no_scan", scan_busy, 0);
    repeat (8) @(negedge clk);
    chk("gameover_no_done", done_cnt - d0, 0);
    chk("gameover_no_overrun", frame_overrun, 0);
    @(negedge clk) begin
      game_restart = 1'b1;
      cube_active = '0;
    end
    @(negedge clk) game_restart = 1'b0;
    chk("restart2_lives", lives, 3);
    chk("restart2_game_over", game_over, 0);
    set_cube(0, 116, 440, 1'b1);
    sb.push_back({4'b0001, 4'b0000});
    tick();
    @(negedge clk);
    chk("pre_reset_catch", catch_pulse, 1);
    chk("pre_reset_score", score, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_score", score, 0);
    chk("async_pulse", catch_pulse, 0);
    chk("async_busy", scan_busy, 0);
    chk("async_lives", lives, 3);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
